pc: RTL and testbench

PC -- requirements
Module: pc

---
 rtl/pc_pkg.sv | 15 +
 rtl/pc.sv | 51 +++++
 tb/tb_pc.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_pkg : shared processor address constants (PC width, vectors)      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pc_pkg;

   localparam int unsigned PC_WIDTH        = 32;
   localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
   localparam int unsigned PC_ALIGN_BITS   = 2;
   localparam int unsigned INSTR_BYTES     = 4;
   localparam logic [31:0] TRAP_VECTOR     = 32'h0000_0100;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc : program-counter register with stall, async clear and +4 output  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pc
   import pc_pkg::*;
#(
   parameter int unsigned      WIDTH        = PC_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
   parameter int unsigned      ALIGN_BITS   = PC_ALIGN_BITS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_pc,
   input  logic [WIDTH-1:0] pc_in,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] pc_plus4,
   output logic             misaligned
);

   logic [WIDTH-1:0] r_pc;
   logic             r_misaligned;
   logic             w_load;
   logic             w_mis_next;

   assign w_load = ~stall_pc;

   // A zero-width alignment field cannot be sliced, so the flag is tied off.
   if (ALIGN_BITS > 0) begin : g_align
      assign w_mis_next = |pc_in[ALIGN_BITS-1:0];
   end else begin : g_no_align
      assign w_mis_next = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc         <= RESET_VECTOR;
         r_misaligned <= 1'b0;
      end else if (w_load) begin
         r_pc         <= pc_in;
         r_misaligned <= w_mis_next;
      end
   end

   assign pc_out     = r_pc;
   assign misaligned = r_misaligned;
   assign pc_plus4   = r_pc + WIDTH'(INSTR_BYTES);

endmodule : pc
`default_nettype wire

// File: tb/tb_pc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pc : scoreboard bench for the pc register                         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pc;

   typedef struct {
      logic [31:0] pc;
      logic        mis;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_pc = 1'b1;
   logic [31:0] pc_in = 32'h0;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic        misaligned;

   int          n_tests = 0;
   int          n_fail  = 0;
   exp_t        sb[$];
   logic [31:0] m_pc;
   logic        m_mis;

   pc dut (
      .clk        (clk),
      .rst        (rst),
      .stall_pc   (stall_pc),
      .pc_in      (pc_in),
      .pc_out     (pc_out),
      .pc_plus4   (pc_plus4),
      .misaligned (misaligned)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic compare_all(input string tag, input exp_t e);
      chk({tag, ".pc"}, pc_out, e.pc);
      chk({tag, ".plus4"}, pc_plus4, e.pc + 32'd4);
      chk({tag, ".mis"}, {31'b0, misaligned}, {31'b0, e.mis});
   endtask

   // Drive one cycle of stimulus, push the model's expectation, then pop and
   // compare once the register has had its edge.
   task automatic step(input string tag, input logic s, input logic [31:0] v);
      exp_t e;
      @(negedge clk);
      stall_pc = s;
      pc_in    = v;
      if (!s) begin
         m_pc  = v;
         m_mis = (v[1:0] != 2'b00);
      end
      e.pc  = m_pc;
      e.mis = m_mis;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
         compare_all(tag, sb.pop_front());
      end
   endtask

   initial begin
      exp_t e;
      // Async reset between edges, checked before the next rising edge.
      #3 rst = 1'b0;
      #1;
      m_pc  = 32'h0;
      m_mis = 1'b0;
      e.pc = m_pc; e.mis = m_mis;
      compare_all("reset_async", e);
      #9 rst = 1'b1;

      step("load4", 1'b0, 32'h4);
      step("load8", 1'b0, 32'h8);
      step("loadC", 1'b0, 32'hC);
      step("stall1", 1'b1, 32'h10);
      step("stall2", 1'b1, 32'h10);
      step("unstall", 1'b0, 32'h14);
      step("wrap", 1'b0, 32'hFFFF_FFFC);
      step("mis6", 1'b0, 32'h6);
      step("align8", 1'b0, 32'h8);
      step("mis3", 1'b0, 32'h3);
      step("load14", 1'b0, 32'h14);
      step("hold14", 1'b1, 32'h20);

      // Reset mid-stall with conflicting inputs: must clear at once.
      @(negedge clk);
      stall_pc = 1'b0;
      pc_in    = 32'h99;
      #2 rst = 1'b0;
      #1;
      m_pc = 32'h0; m_mis = 1'b0;
      e.pc = m_pc; e.mis = m_mis;
      compare_all("rst_stall_now", e);
      @(posedge clk);
      #1;
      compare_all("rst_override", e);
      @(negedge clk);
      stall_pc = 1'b1;
      #2 rst = 1'b1;

      step("post_rst_hold1", 1'b1, 32'h30);
      step("post_rst_hold2", 1'b1, 32'h31);
      step("post_rst_load", 1'b0, 32'h40);

      for (int i = 0; i < 24; i++) begin
         step("rand", ($urandom_range(0, 2) == 0), $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_pc
`default_nettype wire
